// File: rtl/vector_mem_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_mem_unit_if : request, memory and vector-register-file bus bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface vector_mem_unit_if #(
  parameter int DATA_W = 256,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [4:0]        rd_in;
  logic [DATA_W-1:0] store_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;
  logic              vreg_we;
  logic [4:0]        vreg_rd;
  logic [DATA_W-1:0] vreg_wdata;

  // Unit side: takes requests and memory read data, drives everything else.
  modport slave (
    input  start, is_store, base_addr, rd_in, store_data, mem_rdata,
    output busy, done, err, mem_addr, mem_we, mem_wdata, vreg_we, vreg_rd, vreg_wdata
  );

  // Core / memory side.
  modport master (
    output start, is_store, base_addr, rd_in, store_data, mem_rdata,
    input  busy, done, err, mem_addr, mem_we, mem_wdata, vreg_we, vreg_rd, vreg_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vector_mem_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_mem_unit : multi-cycle vector load/store between memory and vector RF
// Rev 1.0
// ---------------------------------------------------------------------------
module vector_mem_unit #(
  parameter int DATA_W = 256,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  vector_mem_unit_if.slave   vmu
);
  localparam int BEATS = DATA_W / MEM_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(MEM_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOAD_TAIL, S_WB, S_STORE, S_FIN, S_REJECT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              vreg_we_q, vreg_we_d;
  logic [4:0]        vreg_rd_q, vreg_rd_d;

  logic [CNT_W-1:0]  cnt_prev, cnt_next;
  assign cnt_prev = cnt_q - CNT_W'(1);
  assign cnt_next = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    vreg_we_d   = 1'b0;
    vreg_rd_d   = vreg_rd_q;
    case (state_q)
      S_IDLE: begin
        if (vmu.start) begin
          if (!vmu.rd_in[4] || (vmu.base_addr[1:0] != 2'b00)) begin
            state_d = S_REJECT;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            cnt_d      = '0;
            mem_addr_d = vmu.base_addr;
            vreg_rd_d  = vmu.rd_in;
            if (vmu.is_store) begin
              // The whole vector is snapshotted here so later store_data changes are ignored.
              state_d     = S_STORE;
              buf_d       = vmu.store_data;
              mem_we_d    = 1'b1;
              mem_wdata_d = vmu.store_data[MEM_W-1:0];
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        // Read data trails the address by one cycle, so beat cnt-1 lands now.
        if (cnt_q != '0) begin
          buf_d[MEM_W*int'(cnt_prev) +: MEM_W] = vmu.mem_rdata;
        end
        if (cnt_q == C_LAST) begin
          state_d = S_LOAD_TAIL;
        end else begin
          cnt_d      = cnt_next;
          mem_addr_d = mem_addr_q + C_STEP;
        end
      end
      S_LOAD_TAIL: begin
        buf_d[MEM_W*int'(C_LAST) +: MEM_W] = vmu.mem_rdata;
        state_d   = S_WB;
        vreg_we_d = 1'b1;
        done_d    = 1'b1;
      end
      S_STORE: begin
        if (cnt_q == C_LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_next;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + C_STEP;
          mem_wdata_d = buf_q[MEM_W*int'(cnt_next) +: MEM_W];
        end
      end
      S_WB, S_FIN, S_REJECT: state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vreg_we_q   <= 1'b0;
      vreg_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vreg_we_q   <= vreg_we_d;
      vreg_rd_q   <= vreg_rd_d;
    end
  end

  assign vmu.busy       = busy_q;
  assign vmu.done       = done_q;
  assign vmu.err        = err_q;
  assign vmu.mem_addr   = mem_addr_q;
  assign vmu.mem_we     = mem_we_q;
  assign vmu.mem_wdata  = mem_wdata_q;
  assign vmu.vreg_we    = vreg_we_q;
  assign vmu.vreg_rd    = vreg_rd_q;
  assign vmu.vreg_wdata = buf_q;
endmodule
`default_nettype wire
